// File: rtl/picomips_pkg.sv
// Shared opcode and decoder-state encodings for the picoMIPS decoder and ALU side.
// Latency: n/a (types only).
// Backpressure: n/a.
package picomips_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LDI   = 4'h1,
        OP_LDSW  = 4'h2,
        OP_LDR   = 4'h3,
        OP_ADDI  = 4'h4,
        OP_ADDR  = 4'h5,
        OP_MULI  = 4'h6,
        OP_ST    = 4'h7,
        OP_JMP   = 4'h8,
        OP_BEQZ  = 4'h9,
        OP_WAITB = 4'hA,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_EXEC    = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_HALT    = 3'd4
    } dec_state_e;

    // ALU / register-file strobes, all low outside EXEC.
    typedef struct packed {
        logic we;
        logic sel_sw;
        logic sel_imm;
        logic sel_reg_data;
        logic use_mul;
        logic use_acc;
        logic reg_we;
    } ctrl_t;

endpackage

// File: rtl/instr_decoder_if.sv
// Decoder <-> program memory / ALU signal bundle; master is the decoder.
// Latency: n/a (wires only).
// Backpressure: none; Instr is expected one cycle after PC.
interface instr_decoder_if #(
    parameter int PC_W = 8,
    parameter int IW   = 16
);
    logic [IW-1:0]   Instr;
    logic [7:0]      ACC;
    logic            Btn;
    logic [PC_W-1:0] PC;
    logic [7:0]      Imm;
    logic [2:0]      RegAddr;
    logic            RegWE;
    logic            WE;
    logic            SelSW;
    logic            SelImm;
    logic            SelRegData;
    logic            UseMul;
    logic            UseACC;
    logic            Halted;

    modport master (
        input  Instr, ACC, Btn,
        output PC, Imm, RegAddr, RegWE, WE, SelSW, SelImm, SelRegData,
               UseMul, UseACC, Halted
    );

    modport slave (
        output Instr, ACC, Btn,
        input  PC, Imm, RegAddr, RegWE, WE, SelSW, SelImm, SelRegData,
               UseMul, UseACC, Halted
    );
endinterface

// File: rtl/btn_sync.sv
// Two-flop synchroniser for the asynchronous push-button.
// Latency: 2 Clock edges from Btn change to btn_sync_o change.
// Backpressure: none.
module btn_sync (
    input  logic Clock,
    input  logic nReset,
    input  logic btn_async,
    output logic btn_sync_o
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Shift the raw button through two stages.
    always_comb begin
        meta_d = btn_async;
        sync_d = meta_q;
    end

    // Synchroniser flops clear on reset so a held button is not seen early.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign btn_sync_o = sync_q;
endmodule

// File: rtl/instr_decoder.sv
// picoMIPS instruction decoder: FETCH/EXEC sequencer with WAITB and HALT.
// Latency: 2 cycles per instruction; controls valid only during EXEC.
// Backpressure: WAITB stalls on synchronised Btn; HALT stalls until reset.
// Optional feature: define DECODER_BRANCH_EN to enable JMP/BEQZ.
module instr_decoder
    import picomips_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int IW   = 16
) (
    input  logic            Clock,
    input  logic            nReset,
    instr_decoder_if.master bus
);
    dec_state_e      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    ctrl_t           ctrl;
    opcode_e         op;
    logic            btn_s;
    logic            unused_in;

    btn_sync u_btn_sync (
        .Clock      (Clock),
        .nReset     (nReset),
        .btn_async  (bus.Btn),
        .btn_sync_o (btn_s)
    );

    assign op     = opcode_e'(bus.Instr[15:12]);
    assign pc_inc = pc_q + PC_W'(1);

`ifdef DECODER_BRANCH_EN
    logic [PC_W-1:0] imm_pc;
    logic            acc_zero;
    // Jump targets: imm zero-extended or truncated to the PC width.
    assign imm_pc   = PC_W'(bus.Instr[7:0]);
    assign acc_zero = (bus.ACC == 8'h00);
`endif

    // Instr[11], any bits above the opcode and (without branches) ACC are not decoded.
    assign unused_in = ^{bus.Instr, bus.ACC};

    // Next state, next PC and the EXEC-only control strobes.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ctrl    = '0;
        case (state_q)
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                case (op)
                    OP_LDI:  begin ctrl.we = 1'b1; ctrl.sel_imm = 1'b1; end
                    OP_LDSW: begin ctrl.we = 1'b1; ctrl.sel_sw = 1'b1; end
                    OP_LDR:  begin ctrl.we = 1'b1; ctrl.sel_reg_data = 1'b1; end
                    OP_ADDI: begin ctrl.we = 1'b1; ctrl.use_acc = 1'b1; ctrl.sel_imm = 1'b1; end
                    OP_ADDR: begin ctrl.we = 1'b1; ctrl.use_acc = 1'b1; ctrl.sel_reg_data = 1'b1; end
                    OP_MULI: begin ctrl.we = 1'b1; ctrl.use_acc = 1'b1; ctrl.use_mul = 1'b1; end
                    OP_ST:   ctrl.reg_we = 1'b1;
`ifdef DECODER_BRANCH_EN
                    OP_JMP:  pc_d = imm_pc;
                    OP_BEQZ: pc_d = acc_zero ? imm_pc : pc_inc;
`endif
                    OP_WAITB: begin state_d = ST_WAIT_HI; pc_d = pc_q; end
                    OP_HALT:  begin state_d = ST_HALT;    pc_d = pc_q; end
                    default: ;
                endcase
            end
            // Press seen (may already be high on entry): move on next edge.
            ST_WAIT_HI: if (btn_s) state_d = ST_WAIT_LO;
            // Release seen: step past the WAITB.
            ST_WAIT_LO: if (!btn_s) begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    // Sequencer state and PC; reset drops everything back to FETCH at 0.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_FETCH;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.PC         = pc_q;
    assign bus.Imm        = bus.Instr[7:0];
    assign bus.RegAddr    = bus.Instr[10:8];
    assign bus.WE         = ctrl.we;
    assign bus.SelSW      = ctrl.sel_sw;
    assign bus.SelImm     = ctrl.sel_imm;
    assign bus.SelRegData = ctrl.sel_reg_data;
    assign bus.UseMul     = ctrl.use_mul;
    assign bus.UseACC     = ctrl.use_acc;
    assign bus.RegWE      = ctrl.reg_we;
    assign bus.Halted     = (state_q == ST_HALT);
endmodule
